qea_run_ctrl: RTL and testbench

- Hardware sequencer for one QEA run: load gate context, initialise state RAM to |0…0>, pulse start, wait for complete, stream the final state vector out.
- Sits between a host streaming interface (valid/ready) and the QEA port set (ctx, state, start, complete).
- Replaces bench-driven sequencing, so runs can be issued back-to-back from a host.

---
 rtl/qea_run_ctrl_pkg.sv | 35 +++
 rtl/qea_rd_hold.sv | 39 +++
 rtl/qea_run_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_qea_run_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_run_ctrl_pkg.sv
// Shared types and fixed-point helpers for the QEA run sequencer.
// State encoding plus complex-amplitude packing at the default widths.
package qea_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CTX,
        INIT_STATE,
        START,
        WAIT_CPL,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } run_state_t;

    localparam int FIX_DW   = 32;
    localparam int FIX_FRAC = 30;
    localparam logic [FIX_DW-1:0] FIX_ONE = FIX_DW'(1) << FIX_FRAC;

    function automatic logic [2*FIX_DW-1:0] amp_pack(
        input logic [FIX_DW-1:0] re,
        input logic [FIX_DW-1:0] im
    );
        return {re, im};
    endfunction

    function automatic logic [FIX_DW-1:0] amp_re(input logic [2*FIX_DW-1:0] a);
        return a[2*FIX_DW-1 -: FIX_DW];
    endfunction

    function automatic logic [FIX_DW-1:0] amp_im(input logic [2*FIX_DW-1:0] a);
        return a[FIX_DW-1:0];
    endfunction

endpackage

// File: rtl/qea_rd_hold.sv
// Readout path: RAM latency delay line feeding a valid/ready hold register.
// Data and last stay frozen from capture until the consumer accepts.
module qea_rd_hold #(
    parameter int ROW_W  = 256,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue,
    input  logic             i_last,
    input  logic [ROW_W-1:0] i_dout,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [ROW_W-1:0] o_data,
    output logic             o_last
);

    logic [RD_LAT-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe    <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else begin
            pipe <= (pipe << 1) | RD_LAT'(i_issue);
            if (pipe[RD_LAT-1]) begin
                o_valid <= 1'b1;
                o_data  <= i_dout;
                o_last  <= i_last;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/qea_run_ctrl.sv
// Sequencer for one QEA run: context load, |0..0> init, start,
// completion wait with watchdog, and streamed state readout.
module qea_run_ctrl
    import qea_run_ctrl_pkg::*;
#(
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int RD_LAT                  = 1,
    parameter int TIMEOUT_WIDTH           = 24
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
    input  logic [TIMEOUT_WIDTH-1:0]             i_timeout,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_qea_ctx_en,
    output logic                                 o_qea_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
    output logic [PE_NUM-1:0]                    o_qea_state_ena,
    output logic [PE_NUM-1:0]                    o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_rd_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err_cfg,
    output logic                                 o_err_timeout
);

    localparam int SDW   = STATE_DATA_WIDTH;
    localparam int ROW_W = PE_NUM * SDW;
    localparam int CAW   = GATE_CONTEXT_ADDR_WIDTH;
    localparam int SAW   = STATE_ADDR_WIDTH;
    localparam int QW    = MAX_QBIT_WIDTH;

    localparam logic [SDW-1:0]   AMP_ONE  = {DATA_WIDTH'(1) << NUM_FRAC_BIT, DATA_WIDTH'(0)};
    localparam logic [ROW_W-1:0] INIT_ROW = {AMP_ONE, {(ROW_W-SDW){1'b0}}};
    localparam logic [CAW:0]     INS_MAX  = (CAW+1)'(1) << CAW;

    run_state_t state, state_n;

    logic [CAW:0]               ins_q, ins_n, ctx_cnt, ctx_cnt_n;
    logic [SAW:0]               row, row_n, rows_m1;
    logic [TIMEOUT_WIDTH-1:0]   wcnt, wcnt_n;
    logic [QW-1:0]              qbit_n;
    logic                       rd_issue, rd_issue_n;
    logic                       rd_fire, rd_last, cfg_bad;
    logic                       ready_n, start_n, ctx_en_n, ctx_wea_n;
    logic [CAW-1:0]             ctx_addr_n;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_n;
    logic [PE_NUM-1:0]          st_ena_n, st_wea_n;
    logic [SAW-1:0]             st_addr_n;
    logic [ROW_W-1:0]           st_din_n;
    logic                       busy_n, done_n, ecfg_n, eto_n;

    assign rows_m1 = ((SAW+1)'(1) << (o_qea_qbit_num - QW'(2))) - 1'b1;
    assign rd_last = (row == rows_m1);
    assign rd_fire = o_rd_valid && i_rd_ready;

    assign cfg_bad = (i_qbit_num < QW'(2))
                  || (int'(i_qbit_num) - 2 > SAW)
                  || (i_ins_num == '0)
                  || (i_ins_num > INS_MAX);

    always_comb begin
        state_n    = state;
        ins_n      = ins_q;
        ctx_cnt_n  = ctx_cnt;
        row_n      = row;
        wcnt_n     = wcnt;
        qbit_n     = o_qea_qbit_num;
        rd_issue_n = 1'b0;
        ready_n    = o_ctx_ready;
        start_n    = 1'b0;
        ctx_en_n   = 1'b0;
        ctx_wea_n  = 1'b0;
        ctx_addr_n = o_qea_ctx_addr;
        ctx_data_n = o_qea_ctx_data;
        st_ena_n   = '0;
        st_wea_n   = '0;
        st_addr_n  = o_qea_state_addra;
        st_din_n   = o_qea_state_dina;
        busy_n     = o_busy;
        done_n     = o_done;
        ecfg_n     = o_err_cfg;
        eto_n      = o_err_timeout;
        unique case (state)
            IDLE: begin
                if (i_run) begin
                    done_n = 1'b0;
                    ecfg_n = cfg_bad;
                    eto_n  = 1'b0;
                    if (!cfg_bad) begin
                        busy_n    = 1'b1;
                        qbit_n    = i_qbit_num;
                        ins_n     = i_ins_num;
                        ctx_cnt_n = '0;
                        ready_n   = 1'b1;
                        state_n   = LOAD_CTX;
                    end
                end
            end
            LOAD_CTX: begin
                if (i_ctx_valid && o_ctx_ready) begin
                    ctx_en_n   = 1'b1;
                    ctx_wea_n  = 1'b1;
                    ctx_addr_n = ctx_cnt[CAW-1:0];
                    ctx_data_n = i_ctx_data;
                    ctx_cnt_n  = ctx_cnt + 1'b1;
                    if (ctx_cnt == ins_q - 1'b1) begin
                        ready_n = 1'b0;
                        row_n   = '0;
                        state_n = INIT_STATE;
                    end
                end
            end
            INIT_STATE: begin
                st_ena_n  = '1;
                st_wea_n  = '1;
                st_addr_n = row[SAW-1:0];
                st_din_n  = (row == '0) ? INIT_ROW : '0;
                row_n     = row + 1'b1;
                if (rd_last) state_n = START;
            end
            START: begin
                start_n = 1'b1;
                wcnt_n  = '0;
                state_n = WAIT_CPL;
            end
            WAIT_CPL: begin
                // complete may linger from the previous run on the first cycle
                wcnt_n = wcnt + 1'b1;
                if (wcnt != '0 && i_qea_complete) begin
                    row_n   = '0;
                    state_n = RD_ISSUE;
                end else if (i_timeout != '0 && wcnt_n == i_timeout) begin
                    eto_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            RD_ISSUE: begin
                st_ena_n   = '1;
                st_addr_n  = row[SAW-1:0];
                rd_issue_n = 1'b1;
                state_n    = RD_WAIT;
            end
            RD_WAIT, RD_HOLD: begin
                if (rd_fire) begin
                    if (rd_last) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        row_n   = row + 1'b1;
                        state_n = RD_ISSUE;
                    end
                end else if (o_rd_valid) begin
                    state_n = RD_HOLD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ins_q             <= '0;
            ctx_cnt           <= '0;
            row               <= '0;
            wcnt              <= '0;
            rd_issue          <= 1'b0;
            o_qea_qbit_num    <= '0;
            o_ctx_ready       <= 1'b0;
            o_qea_start       <= 1'b0;
            o_qea_ctx_en      <= 1'b0;
            o_qea_ctx_wea     <= 1'b0;
            o_qea_ctx_addr    <= '0;
            o_qea_ctx_data    <= '0;
            o_qea_state_ena   <= '0;
            o_qea_state_wea   <= '0;
            o_qea_state_addra <= '0;
            o_qea_state_dina  <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_err_cfg         <= 1'b0;
            o_err_timeout     <= 1'b0;
        end else begin
            state             <= state_n;
            ins_q             <= ins_n;
            ctx_cnt           <= ctx_cnt_n;
            row               <= row_n;
            wcnt              <= wcnt_n;
            rd_issue          <= rd_issue_n;
            o_qea_qbit_num    <= qbit_n;
            o_ctx_ready       <= ready_n;
            o_qea_start       <= start_n;
            o_qea_ctx_en      <= ctx_en_n;
            o_qea_ctx_wea     <= ctx_wea_n;
            o_qea_ctx_addr    <= ctx_addr_n;
            o_qea_ctx_data    <= ctx_data_n;
            o_qea_state_ena   <= st_ena_n;
            o_qea_state_wea   <= st_wea_n;
            o_qea_state_addra <= st_addr_n;
            o_qea_state_dina  <= st_din_n;
            o_busy            <= busy_n;
            o_done            <= done_n;
            o_err_cfg         <= ecfg_n;
            o_err_timeout     <= eto_n;
        end
    end

    qea_rd_hold #(
        .ROW_W  (ROW_W),
        .RD_LAT (RD_LAT)
    ) u_rd_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_issue (rd_issue),
        .i_last  (rd_last),
        .i_dout  (i_qea_state_dout),
        .i_ready (i_rd_ready),
        .o_valid (o_rd_valid),
        .o_data  (o_rd_data),
        .o_last  (o_rd_last)
    );

endmodule

// File: tb/tb_qea_run_ctrl.sv
// Bench for qea_run_ctrl: context/readout scoreboards, QEA and RAM models.
// Covers full runs, stalled readout, config errors, watchdog and abort.
module tb_qea_run_ctrl;
    import qea_run_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_run = 1'b0;
    logic [5:0]   i_qbit_num = '0;
    logic [16:0]  i_ins_num = '0;
    logic [23:0]  i_timeout = '0;
    logic         i_ctx_valid = 1'b0;
    logic         o_ctx_ready;
    logic [63:0]  i_ctx_data = '0;
    logic         o_qea_start;
    logic [5:0]   o_qea_qbit_num;
    logic         o_qea_ctx_en, o_qea_ctx_wea;
    logic [15:0]  o_qea_ctx_addr;
    logic [63:0]  o_qea_ctx_data;
    logic [3:0]   o_qea_state_ena, o_qea_state_wea;
    logic [15:0]  o_qea_state_addra;
    logic [255:0] o_qea_state_dina;
    logic         i_qea_complete = 1'b0;
    logic [255:0] i_qea_state_dout = '0;
    logic         o_rd_valid;
    logic         i_rd_ready = 1'b0;
    logic [255:0] o_rd_data;
    logic         o_rd_last;
    logic         o_busy, o_done, o_err_cfg, o_err_timeout;

    localparam logic [255:0] INIT_ROW = {amp_pack(FIX_ONE, 32'd0), 192'd0};

    int n_chk = 0;
    int n_fail = 0;
    int run_id = 0;
    logic [79:0]  ctx_q[$];
    logic [256:0] rd_q[$];

    qea_run_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_run             (i_run),
        .i_qbit_num        (i_qbit_num),
        .i_ins_num         (i_ins_num),
        .i_timeout         (i_timeout),
        .i_ctx_valid       (i_ctx_valid),
        .o_ctx_ready       (o_ctx_ready),
        .i_ctx_data        (i_ctx_data),
        .o_qea_start       (o_qea_start),
        .o_qea_qbit_num    (o_qea_qbit_num),
        .o_qea_ctx_en      (o_qea_ctx_en),
        .o_qea_ctx_wea     (o_qea_ctx_wea),
        .o_qea_ctx_addr    (o_qea_ctx_addr),
        .o_qea_ctx_data    (o_qea_ctx_data),
        .o_qea_state_ena   (o_qea_state_ena),
        .o_qea_state_wea   (o_qea_state_wea),
        .o_qea_state_addra (o_qea_state_addra),
        .o_qea_state_dina  (o_qea_state_dina),
        .i_qea_complete    (i_qea_complete),
        .i_qea_state_dout  (i_qea_state_dout),
        .o_rd_valid        (o_rd_valid),
        .i_rd_ready        (i_rd_ready),
        .o_rd_data         (o_rd_data),
        .o_rd_last         (o_rd_last),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err_cfg         (o_err_cfg),
        .o_err_timeout     (o_err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input int r, input int id);
        logic [255:0] v;
        for (int p = 0; p < 4; p++)
            v[p*64 +: 64] = amp_pack(32'(id*4096 + r*16 + p), ~32'(r*5 + p));
        return v;
    endfunction

    // final state as left by the QEA model, one-cycle read latency
    always @(posedge clk)
        if (o_qea_state_ena != '0 && o_qea_state_wea == '0)
            i_qea_state_dout <= pat(int'(o_qea_state_addra), run_id);

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_status"}, {o_ctx_ready, o_qea_start, o_qea_qbit_num, o_busy,
              o_done, o_err_cfg, o_err_timeout, o_rd_valid, o_rd_last}, '0);
        check({tag, "_ctx"}, {o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data}, '0);
        check({tag, "_state"}, {o_qea_state_ena, o_qea_state_wea, o_qea_state_addra,
              o_qea_state_dina}, '0);
        check({tag, "_rd"}, o_rd_data, '0);
    endtask

    task automatic do_run(input int qbit, input int ins, input int vmode, input int rmode,
                          input int tmo, input int abort_at, input bit poke);
        int  rows, k_sent, n_init, n_iss, n_start, strobes, t_start, first_en, last_en;
        bit  good, ended, cpl_flag, prev_hold;
        logic [255:0] prev_data;
        logic [3:0] rpat;
        rpat = 4'b1001;
        good = qbit >= 2 && qbit - 2 <= 16 && ins != 0 && ins <= 65536;
        rows = good ? (1 << (qbit - 2)) : 0;
        run_id++;
        ctx_q.delete();
        rd_q.delete();
        if (good && tmo == 0 && abort_at < 0)
            for (int r = 0; r < rows; r++)
                rd_q.push_back({r == rows - 1, pat(r, run_id)});
        k_sent = 0; n_init = 0; n_iss = 0; n_start = 0; strobes = 0;
        t_start = -1; first_en = -1; last_en = -1;
        ended = 0; cpl_flag = 0; prev_hold = 0; prev_data = '0;
        @(negedge clk);
        i_qbit_num = 6'(qbit);
        i_ins_num  = 17'(ins);
        i_timeout  = 24'(tmo);
        i_run      = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if (abort_at >= 0 && k_sent == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_quiet("abort");
                i_ctx_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                ended = 1;
                break;
            end
            if (o_qea_ctx_en) begin
                if (first_en < 0) first_en = t;
                last_en = t;
                if (ctx_q.size() > 0)
                    check("ctx_wr", {o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data},
                          {1'b1, ctx_q.pop_front()});
                else
                    check("ctx_extra", 1, 0);
            end
            if (o_qea_state_ena == '1 && o_qea_state_wea == '1) begin
                check("init_row", {o_qea_state_addra, o_qea_state_dina},
                      {16'(n_init), (n_init == 0) ? INIT_ROW : 256'd0});
                n_init++;
            end
            if (o_qea_state_ena == '1 && o_qea_state_wea == '0) begin
                check("rd_issue", {cpl_flag, o_qea_state_addra}, {1'b1, 16'(n_iss)});
                n_iss++;
            end
            if (o_qea_start) begin
                n_start++;
                if (t_start < 0) t_start = t;
            end
            if (o_qea_ctx_en || o_qea_state_ena != '0 || o_qea_start) strobes++;
            if (tmo != 0 && t_start >= 0 && t == t_start + 49)
                check("to_early", o_err_timeout, 0);
            if (tmo != 0 && t_start >= 0 && t == t_start + 50)
                check("to_fire", {o_err_timeout, o_busy}, 2'b10);
            if (prev_hold)
                check("rd_hold", {o_rd_valid, o_rd_data}, {1'b1, prev_data});
            if (t >= 4 && !o_busy) begin
                ended = 1;
                break;
            end
            i_run = poke && t == 100;
            i_qbit_num = (poke && t == 100) ? 6'd1 : 6'(qbit);
            if (!(i_ctx_valid && !o_ctx_ready)) begin
                i_ctx_valid = 1'b0;
                if (good && k_sent < ins && (vmode == 0 || $urandom_range(0, 2) != 0)) begin
                    i_ctx_valid = 1'b1;
                    i_ctx_data  = {$urandom, $urandom};
                end
            end
            if (i_ctx_valid && o_ctx_ready) begin
                ctx_q.push_back({16'(k_sent), i_ctx_data});
                k_sent++;
            end
            if (t_start >= 0 && t == t_start + 1) i_qea_complete = 1'b0;
            if (tmo == 0 && t_start >= 0 && t == t_start + 20) begin
                i_qea_complete = 1'b1;
                cpl_flag = 1;
            end
            i_rd_ready = (rmode == 0) ? 1'b1 : rpat[t % 4];
            if (o_rd_valid && i_rd_ready) begin
                if (rd_q.size() > 0)
                    check("rd_row", {o_rd_last, o_rd_data}, rd_q.pop_front());
                else
                    check("rd_extra", 1, 0);
            end
            prev_hold = o_rd_valid && !i_rd_ready;
            prev_data = o_rd_data;
            @(negedge clk);
        end
        i_run = 1'b0;
        i_ctx_valid = 1'b0;
        if (!ended) check("budget", 0, 1);
        if (abort_at >= 0) begin
            check("abort_busy", o_busy, 0);
        end else if (!good) begin
            check("cfg_err", {o_err_cfg, o_busy, o_done}, 3'b100);
            check("cfg_quiet", strobes, 0);
        end else if (tmo != 0) begin
            check("to_flags", {o_err_timeout, o_err_cfg, o_done, o_busy}, 4'b1000);
            check("to_nord", n_iss, 0);
        end else begin
            check("run_flags", {o_done, o_busy, o_err_cfg, o_err_timeout}, 4'b1000);
            check("run_counts", {16'(n_init), 16'(n_iss), 8'(n_start)},
                  {16'(rows), 16'(rows), 8'd1});
            check("run_left", rd_q.size() + ctx_q.size(), 0);
            check("qbit_latch", o_qea_qbit_num, 6'(qbit));
            if (vmode == 0) check("ctx_span", last_en - first_en, ins - 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        i_qea_complete = 1'b1;
        do_run(6, 183, 0, 0, 0, -1, 1'b1);
        do_run(4, 7, 1, 1, 0, -1, 1'b0);
        do_run(1, 5, 0, 0, 0, -1, 1'b0);
        do_run(4, 0, 0, 0, 0, -1, 1'b0);
        do_run(19, 5, 0, 0, 0, -1, 1'b0);
        do_run(3, 65537, 0, 0, 0, -1, 1'b0);
        do_run(3, 3, 0, 0, 50, -1, 1'b0);
        do_run(6, 183, 0, 0, 0, 90, 1'b0);
        do_run(2, 5, 1, 0, 0, -1, 1'b0);
        do_run(3, 9, 0, 1, 0, -1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
